// File: rtl/cpu_multicycle.sv
// Multicycle 16-bit-ISA core with a single shared memory port.
//
// The FSM sequences BOOT -> FETCH -> DECODE -> EXEC [-> MEM] -> FETCH. One memory
// port serves both instruction fetch and ld/st. The memory can stall any access
// with i_mem_waitrequest.
//
// Ports:
//   clk                rising-edge clock
//   reset              asynchronous active-low reset
//   o_mem_addr         byte address: PC during fetch, Ry during ld/st
//   o_mem_rd/o_mem_wr  read / write request; never both set
//   o_mem_wrdata       store data (Rx operand latch)
//   i_mem_rddata       read data; consumed when a read is not stalled
//   i_mem_waitrequest  memory stall; the current request is held while set
//   o_retire           one-cycle pulse in the last cycle of each instruction
//   o_pc               current PC, for debug
module cpu_multicycle #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [DATA_W-1:0] o_mem_wrdata,
  input  logic [DATA_W-1:0] i_mem_rddata,
  input  logic              i_mem_waitrequest,
  output logic              o_retire,
  output logic [ADDR_W-1:0] o_pc
);

  localparam logic [3:0] OpMv   = 4'd0;
  localparam logic [3:0] OpAdd  = 4'd1;
  localparam logic [3:0] OpSub  = 4'd2;
  localparam logic [3:0] OpCmp  = 4'd3;
  localparam logic [3:0] OpLd   = 4'd4;
  localparam logic [3:0] OpSt   = 4'd5;
  localparam logic [3:0] OpMvhi = 4'd6;
  localparam logic [3:0] OpJ    = 4'd8;
  localparam logic [3:0] OpJz   = 4'd9;
  localparam logic [3:0] OpJn   = 4'd10;
  localparam logic [3:0] OpCall = 4'd12;

  typedef enum logic [2:0] {StBoot, StFetch, StDecode, StExec, StMem} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] rx_val_q, rx_val_d;
  logic [DATA_W-1:0] ry_val_q, ry_val_d;
  logic              n_q, n_d, z_q, z_d;
  logic [DATA_W-1:0] regs_q [8];

  logic              rf_we;
  logic [2:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  // Instruction fields
  logic [3:0]        op;
  logic              imm_flag;
  logic [2:0]        rx_idx, ry_idx;
  logic [DATA_W-1:0] imm8_ext, opnd_b, sum, diff, ret_addr;
  logic [ADDR_W-1:0] br_off, rx_addr, ry_addr, br_tgt;

  assign op       = ir_q[3:0];
  assign imm_flag = ir_q[4];
  assign rx_idx   = ir_q[7:5];
  assign ry_idx   = ir_q[10:8];
  assign imm8_ext = DATA_W'($signed(ir_q[15:8]));
  assign opnd_b   = imm_flag ? imm8_ext : ry_val_q;
  assign sum      = rx_val_q + opnd_b;
  assign diff     = rx_val_q - opnd_b;

  // Sign-extended halfword offset; size casts cover any ADDR_W/DATA_W mix.
  assign br_off   = ADDR_W'($signed({ir_q[15:5], 1'b0}));
  assign rx_addr  = ADDR_W'(rx_val_q);
  assign ry_addr  = ADDR_W'(ry_val_q);
  assign ret_addr = DATA_W'(pc_q);
  // pc_q is already incremented when EXEC runs; rx_val_q holds the old Rx (old R7 for call R7).
  assign br_tgt   = imm_flag ? pc_q + br_off : rx_addr;

  assign o_mem_wrdata = rx_val_q;
  assign o_pc         = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    rx_val_d   = rx_val_q;
    ry_val_d   = ry_val_q;
    n_d        = n_q;
    z_d        = z_q;
    rf_we      = 1'b0;
    rf_waddr   = rx_idx;
    rf_wdata   = rx_val_q;
    o_mem_rd   = 1'b0;
    o_mem_wr   = 1'b0;
    o_mem_addr = pc_q;
    o_retire   = 1'b0;

    unique case (state_q)
      StBoot: state_d = StFetch;

      StFetch: begin
        o_mem_rd = 1'b1;
        if (!i_mem_waitrequest) begin
          ir_d    = i_mem_rddata[15:0];
          pc_d    = pc_q + ADDR_W'(2);
          state_d = StDecode;
        end
      end

      StDecode: begin
        rx_val_d = regs_q[rx_idx];
        ry_val_d = regs_q[ry_idx];
        state_d  = StExec;
      end

      StExec: begin
        state_d  = StFetch;
        o_retire = 1'b1;
        case (op)
          OpMv: begin
            rf_we    = 1'b1;
            rf_wdata = opnd_b;
          end
          OpAdd: begin
            rf_we    = 1'b1;
            rf_wdata = sum;
            n_d      = sum[DATA_W-1];
            z_d      = (sum == '0);
          end
          OpSub: begin
            rf_we    = 1'b1;
            rf_wdata = diff;
            n_d      = diff[DATA_W-1];
            z_d      = (diff == '0);
          end
          OpCmp: begin
            n_d = diff[DATA_W-1];
            z_d = (diff == '0);
          end
          OpLd, OpSt: begin
            state_d  = StMem;
            o_retire = 1'b0;
          end
          OpMvhi: begin
            rf_we          = 1'b1;
            rf_wdata[15:8] = ir_q[15:8];
          end
          OpJ: pc_d = br_tgt;
          OpJz: if (z_q) pc_d = br_tgt;
          OpJn: if (n_q) pc_d = br_tgt;
          OpCall: begin
            rf_we    = 1'b1;
            rf_waddr = 3'd7;
            rf_wdata = ret_addr;
            pc_d     = br_tgt;
          end
          default: ;
        endcase
      end

      StMem: begin
        o_mem_addr = ry_addr;
        if (op == OpLd) o_mem_rd = 1'b1;
        else            o_mem_wr = 1'b1;
        if (!i_mem_waitrequest) begin
          o_retire = 1'b1;
          state_d  = StFetch;
          if (op == OpLd) begin
            rf_we    = 1'b1;
            rf_wdata = i_mem_rddata;
          end
        end
      end

      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      rx_val_q <= '0;
      ry_val_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      rx_val_q <= rx_val_d;
      ry_val_q <= ry_val_d;
      n_q      <= n_d;
      z_q      <= z_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: reset/boot sequence, a directed program table with
// hand-computed fetch addresses, latencies and store values, then random code
// checked against an instruction-level model.
module tb_cpu_multicycle;

  localparam int          DW  = 16;
  localparam int          AW  = 16;
  localparam logic [15:0] RPC = 16'h0100;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_rd, o_mem_wr;
  logic [DW-1:0] o_mem_wrdata;
  logic [DW-1:0] i_mem_rddata;
  logic          i_mem_waitrequest = 1'b0;
  logic          o_retire;
  logic [AW-1:0] o_pc;

  cpu_multicycle #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk              (clk),
    .reset            (reset),
    .o_mem_addr       (o_mem_addr),
    .o_mem_rd         (o_mem_rd),
    .o_mem_wr         (o_mem_wr),
    .o_mem_wrdata     (o_mem_wrdata),
    .i_mem_rddata     (i_mem_rddata),
    .i_mem_waitrequest(i_mem_waitrequest),
    .o_retire         (o_retire),
    .o_pc             (o_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bus memory seen by the DUT, and the model's own copy.
  logic [15:0] mem   [32768];
  logic [15:0] m_mem [32768];
  logic [15:0] m_r   [8];
  logic [15:0] m_pc;
  logic        m_n, m_z;

  assign i_mem_rddata = mem[o_mem_addr[15:1]];

  initial begin
    forever begin
      @(posedge clk);
      if (reset && o_mem_wr && !i_mem_waitrequest) mem[o_mem_addr[15:1]] = o_mem_wrdata;
    end
  end

  // Wait-state driver: one stall count per bus transaction, from the queue
  // if present, else random (when enabled) or zero.
  int stall_q[$];
  bit rand_en = 1'b0;
  bit cur_active = 1'b0;
  int cur_stall = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (o_mem_rd || o_mem_wr) begin
        if (!cur_active) begin
          cur_active = 1'b1;
          if (stall_q.size() > 0) cur_stall = stall_q.pop_front();
          else if (rand_en && $urandom_range(0, 3) == 0) cur_stall = $urandom_range(1, 3);
          else cur_stall = 0;
        end
        if (cur_stall > 0) begin
          i_mem_waitrequest = 1'b1;
          cur_stall--;
        end else begin
          i_mem_waitrequest = 1'b0;
          cur_active = 1'b0;
        end
      end else begin
        i_mem_waitrequest = 1'b0;
        cur_active = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] e_r(input logic [3:0] op, input logic [2:0] rx,
                                      input logic [2:0] ry);
    return {5'b0, ry, rx, 1'b0, op};
  endfunction

  function automatic logic [15:0] e_i(input logic [3:0] op, input logic [2:0] rx,
                                      input logic [7:0] imm8);
    return {imm8, rx, 1'b1, op};
  endfunction

  function automatic logic [15:0] e_b(input logic [3:0] op, input logic [10:0] off);
    return {off, 1'b1, op};
  endfunction

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    int          fstall;
    int          mstall;
    int          cycles;
    bit          st;
    logic [15:0] st_addr;
    logic [15:0] st_data;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] addr, input logic [15:0] instr,
                              input int fs, input int ms, input int cyc, input bit st,
                              input logic [15:0] sa, input logic [15:0] sd);
    vec_t v;
    v.addr = addr; v.instr = instr; v.fstall = fs; v.mstall = ms;
    v.cycles = cyc; v.st = st; v.st_addr = sa; v.st_data = sd;
    return v;
  endfunction

  // Instruction-level model: executes one instruction on the model state.
  task automatic model_exec(input logic [15:0] ins, output bit ld, output bit st,
                            output logic [15:0] maddr, output logic [15:0] wdat);
    logic [3:0]  op;
    logic [15:0] b, res, tgt;
    int          x, y;
    op = ins[3:0];
    x  = int'(ins[7:5]);
    y  = int'(ins[10:8]);
    ld = 1'b0; st = 1'b0; maddr = '0; wdat = '0;
    m_pc = m_pc + 16'd2;
    b   = ins[4] ? {{8{ins[15]}}, ins[15:8]} : m_r[y];
    tgt = ins[4] ? m_pc + {{4{ins[15]}}, ins[15:5], 1'b0} : m_r[x];
    case (op)
      4'd0: m_r[x] = b;
      4'd1: begin res = m_r[x] + b; m_r[x] = res; m_n = res[15]; m_z = (res == 0); end
      4'd2: begin res = m_r[x] - b; m_r[x] = res; m_n = res[15]; m_z = (res == 0); end
      4'd3: begin res = m_r[x] - b; m_n = res[15]; m_z = (res == 0); end
      4'd4: begin ld = 1'b1; maddr = m_r[y]; m_r[x] = m_mem[maddr[15:1]]; end
      4'd5: begin st = 1'b1; maddr = m_r[y]; wdat = m_r[x]; m_mem[maddr[15:1]] = wdat; end
      4'd6: m_r[x][15:8] = ins[15:8];
      4'd8: m_pc = tgt;
      4'd9: if (m_z) m_pc = tgt;
      4'd10: if (m_n) m_pc = tgt;
      4'd12: begin m_r[7] = m_pc; m_pc = tgt; end
      default: ;
    endcase
  endtask

  // Runs one instruction starting at the negedge after the previous retire.
  task automatic run_one(input bit use_tab, input vec_t t);
    logic [15:0] ins, fa, maddr, wdat, obs_a, obs_d;
    bit          ld, st, fdone, ret;
    int          cyc, waits, post;
    fa  = m_pc;
    ins = m_mem[m_pc[15:1]];
    model_exec(ins, ld, st, maddr, wdat);
    if (use_tab) begin
      stall_q.push_back(t.fstall);
      if (ld || st) stall_q.push_back(t.mstall);
    end
    @(negedge clk);
    chk("fetch_start", 32'(o_mem_rd), 32'd1);
    chk("fetch_addr", 32'(o_mem_addr), 32'(fa));
    chk("debug_pc", 32'(o_pc), 32'(fa));
    if (use_tab) chk("tab_fetch_addr", 32'(o_mem_addr), 32'(t.addr));
    cyc = 0; waits = 0; post = 0; fdone = 1'b0; ret = 1'b0;
    obs_a = '0; obs_d = '0;
    for (int i = 0; i < 64 && !ret; i++) begin
      if (i > 0) @(negedge clk);
      cyc++;
      chk("rd_wr_exclusive", 32'(o_mem_rd && o_mem_wr), 32'd0);
      if (!fdone) begin
        chk("fetch_hold_rd", 32'(o_mem_rd), 32'd1);
        chk("fetch_hold_addr", 32'(o_mem_addr), 32'(fa));
        if (i_mem_waitrequest) waits++;
        else fdone = 1'b1;
      end else begin
        post++;
        if (post <= 2) begin
          chk("idle_bus", 32'({o_mem_rd, o_mem_wr}), 32'd0);
        end else begin
          chk("mem_rd", 32'(o_mem_rd), 32'(ld));
          chk("mem_wr", 32'(o_mem_wr), 32'(st));
          chk("mem_addr", 32'(o_mem_addr), 32'(maddr));
          if (st) chk("mem_wrdata", 32'(o_mem_wrdata), 32'(wdat));
          obs_a = o_mem_addr;
          obs_d = o_mem_wrdata;
          if (i_mem_waitrequest) waits++;
        end
      end
      ret = o_retire;
    end
    if (!ret) begin
      checks++;
      errors++;
      $display("FAIL retire_timeout: got no retire in 64 cycles, expected one (fetch %0h)", fa);
    end
    chk("latency", 32'(cyc), 32'(3 + int'(ld || st) + waits));
    if (use_tab) begin
      chk("tab_latency", 32'(cyc), 32'(t.cycles));
      if (t.st) begin
        chk("tab_st_addr", 32'(obs_a), 32'(t.st_addr));
        chk("tab_st_data", 32'(obs_d), 32'(t.st_data));
      end
    end
  endtask

  vec_t tab[$];

  initial begin
    logic [15:0] w;
    tab.push_back(mk(16'h0100, e_i(0, 1, 8'h05), 0, 0, 3, 0, 0, 0));       // mv R1,#5
    tab.push_back(mk(16'h0102, e_i(2, 1, 8'h05), 0, 0, 3, 0, 0, 0));       // sub R1,#5 -> Z
    tab.push_back(mk(16'h0104, e_b(9, 11'd1), 0, 0, 3, 0, 0, 0));         // jz taken
    tab.push_back(mk(16'h0108, e_i(2, 1, 8'h01), 0, 0, 3, 0, 0, 0));       // sub -> FFFF, N
    tab.push_back(mk(16'h010A, e_b(10, 11'd1), 0, 0, 3, 0, 0, 0));        // jn taken
    tab.push_back(mk(16'h010E, e_b(9, 11'd1), 0, 0, 3, 0, 0, 0));         // jz not taken
    tab.push_back(mk(16'h0110, e_i(0, 4, 8'h40), 0, 0, 3, 0, 0, 0));       // mv R4,#40
    tab.push_back(mk(16'h0112, e_r(5, 1, 4), 0, 0, 4, 1, 16'h0040, 16'hFFFF));
    tab.push_back(mk(16'h0114, e_r(3, 2, 2), 0, 0, 3, 0, 0, 0));           // cmp R2,R2
    tab.push_back(mk(16'h0116, e_b(9, 11'd4), 0, 0, 3, 0, 0, 0));         // jz +4
    tab.push_back(mk(16'h0120, e_b(10, 11'd1), 0, 0, 3, 0, 0, 0));        // jn not taken
    tab.push_back(mk(16'h0122, e_i(0, 3, 8'hEF), 0, 0, 3, 0, 0, 0));       // R3=FFEF
    tab.push_back(mk(16'h0124, e_i(6, 3, 8'hBE), 0, 0, 3, 0, 0, 0));       // R3=BEEF
    tab.push_back(mk(16'h0126, e_r(5, 3, 4), 3, 2, 9, 1, 16'h0040, 16'hBEEF));
    tab.push_back(mk(16'h0128, e_r(4, 4, 4), 0, 0, 4, 0, 0, 0));           // ld R4,[R4]
    tab.push_back(mk(16'h012A, e_i(0, 6, 8'h50), 0, 0, 3, 0, 0, 0));       // R6=0050
    tab.push_back(mk(16'h012C, e_r(5, 4, 6), 0, 0, 4, 1, 16'h0050, 16'hBEEF));
    tab.push_back(mk(16'h012E, e_i(0, 5, 8'h34), 0, 0, 3, 0, 0, 0));       // R5=0034
    tab.push_back(mk(16'h0130, e_i(6, 5, 8'h12), 0, 0, 3, 0, 0, 0));       // R5=1234
    tab.push_back(mk(16'h0132, e_r(5, 5, 6), 0, 0, 4, 1, 16'h0050, 16'h1234));
    tab.push_back(mk(16'h0134, 16'h000F, 0, 0, 3, 0, 0, 0));                 // op 15 NOP
    tab.push_back(mk(16'h0136, e_b(9, 11'd1), 0, 0, 3, 0, 0, 0));         // Z kept -> taken
    tab.push_back(mk(16'h013A, e_i(0, 7, 8'h60), 0, 0, 3, 0, 0, 0));       // R7=0060
    tab.push_back(mk(16'h013C, e_r(12, 7, 0), 0, 0, 3, 0, 0, 0));          // call R7
    tab.push_back(mk(16'h0060, e_r(5, 7, 6), 0, 0, 4, 1, 16'h0050, 16'h013E));
    tab.push_back(mk(16'h0062, e_i(0, 2, 8'hFE), 0, 0, 3, 0, 0, 0));       // R2=FFFE
    tab.push_back(mk(16'h0064, e_r(8, 2, 0), 0, 0, 3, 0, 0, 0));           // j R2
    tab.push_back(mk(16'hFFFE, e_i(0, 0, 8'h01), 0, 0, 3, 0, 0, 0));       // wraps to 0
    tab.push_back(mk(16'h0000, e_r(5, 0, 6), 0, 0, 4, 1, 16'h0050, 16'h0001));

    for (int i = 0; i < 32768; i++) begin
      w = 16'($urandom);
      mem[i]   = w;
      m_mem[i] = w;
    end
    foreach (tab[i]) begin
      mem[tab[i].addr[15:1]]   = tab[i].instr;
      m_mem[tab[i].addr[15:1]] = tab[i].instr;
    end
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_pc = RPC;
    m_n  = 1'b0;
    m_z  = 1'b0;

    // Reset, boot, then reset again in the middle of a stalled fetch.
    repeat (2) @(negedge clk);
    chk("rst_rd", 32'(o_mem_rd), 32'd0);
    chk("rst_addr", 32'(o_mem_addr), 32'(RPC));
    stall_q.push_back(20);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("prerst_fetch_rd", 32'(o_mem_rd), 32'd1);
    chk("prerst_fetch_addr", 32'(o_mem_addr), 32'(RPC));
    #2 reset = 1'b0;
    #1;
    chk("rst_async_rd", 32'(o_mem_rd), 32'd0);
    chk("rst_async_wr", 32'(o_mem_wr), 32'd0);
    chk("rst_async_retire", 32'(o_retire), 32'd0);
    chk("rst_async_addr", 32'(o_mem_addr), 32'(RPC));
    chk("rst_async_wrdata", 32'(o_mem_wrdata), 32'd0);
    chk("rst_async_pc", 32'(o_pc), 32'(RPC));
    stall_q.delete();
    cur_active = 1'b0;
    cur_stall = 0;
    i_mem_waitrequest = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("boot_no_rd", 32'(o_mem_rd), 32'd0);

    foreach (tab[i]) run_one(1'b1, tab[i]);

    rand_en = 1'b1;
    for (int k = 0; k < 300; k++) run_one(1'b0, tab[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test by %0t, expected earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
- Parametrised multicycle successor to the single-cycle 16-bit core.
- FSM-sequenced datapath: fetch, decode, execute and memory run in separate cycles over one shared memory port.
- The memory port supports wait states via `i_mem_waitrequest`.
- Generalised data and address widths, a configurable reset vector, conditional branches on N/Z flags, and a retire pulse for verification.

Parameters:
- DATA_W, 16: register/ALU/memory data width; must be ≥16.
- ADDR_W, 16: memory byte-address width.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- o_mem_addr  out  ADDR_W  byte address; PC in FETCH, Ry[ADDR_W-1:0] in MEM.
- o_mem_rd  out  1  read request.
- o_mem_wr  out  1  write request.
- o_mem_wrdata  out  DATA_W  store data (Rx).
- i_mem_rddata  in  DATA_W  read data; valid when o_mem_rd=1 and i_mem_waitrequest=0.
- i_mem_waitrequest  in  1  memory stall; the request is held while this is 1.
- o_retire  out  1  one-cycle pulse in the final cycle of each instruction.
- o_pc  out  ADDR_W  current PC (debug).

Behaviour:
- Instruction format: 16 bits, taken from i_mem_rddata[15:0].
  - [3:0] op; [4] imm flag; [7:5] Rx; [10:8] Ry.
  - [15:8] imm8, sign-extended to DATA_W.
  - [15:5] imm11 (branches).
- Register file: 8 × DATA_W. Flags N and Z.
- Operations:
  - op0 mv: Rx = Ry or imm.
  - op1 add: Rx = Rx + (Ry or imm).
  - op2 sub: Rx = Rx - (Ry or imm).
  - op3 cmp: compute Rx - (Ry or imm), flags only.
  - op4 ld: Rx = mem[Ry].
  - op5 st: mem[Ry] = Rx.
  - op6 mvhi: Rx[15:8] = imm8, other bits unchanged.
  - op8 j; op9 jz (taken if Z); op10 jn (taken if N).
  - op12 call: R7 = PC, then jump.
  - Any other op: NOP.
- Flags: add, sub and cmp update N = result[DATA_W-1] and Z = (result==0). All other ops leave flags unchanged.
- Arithmetic: modulo 2^DATA_W; no carry or overflow output.
- Branch target:
  - imm=1: PC + 2*sext(imm11), where PC has already been incremented.
  - imm=0: Rx.
  - Branch/call targets are truncated to ADDR_W.
  - call with Rx=R7 (register form): the jump uses the old R7; R7 is then written with the return address.
- FSM states: BOOT, FETCH, DECODE, EXEC, MEM.
- Reset (async, any state, including mid-transaction):
  - state=BOOT, PC=RESET_PC.
  - All registers, N and Z = 0.
  - o_mem_rd=0, o_mem_wr=0, o_retire=0, o_mem_wrdata=0, o_mem_addr=RESET_PC.
  - An in-flight access is abandoned.
- BOOT: goes to FETCH on the next clk.
- FETCH:
  - Drives o_mem_rd=1, o_mem_addr=PC.
  - Stays in FETCH while waitrequest=1.
  - When waitrequest=0: IR ← rddata[15:0], PC ← PC+2 (wraps at 2^ADDR_W), go to DECODE.
- DECODE: reads Rx/Ry into operand latches; goes to EXEC.
- EXEC:
  - ALU, mv, mvhi, branch, call and NOP complete here: register, flag and PC writes, o_retire=1, then FETCH.
  - ld/st go to MEM.
- MEM, ld:
  - o_mem_rd=1, addr=Ry.
  - On waitrequest=0: Rx ← rddata, o_retire=1, then FETCH.
- MEM, st:
  - o_mem_wr=1, addr=Ry, wrdata=Rx.
  - Held stable until waitrequest=0; then o_retire=1, then FETCH.
- Invariants:
  - o_mem_rd and o_mem_wr are never both 1.
  - Request outputs change only on clk edges or on reset.
- Latency with zero wait states: 3 cycles for non-memory instructions, 4 for ld/st. Each waitrequest cycle adds 1.
- ld into Ry (Rx==Ry): the address uses the old Ry.

Test Plan:
- Reset and boot: assert reset mid-FETCH with RESET_PC=0x0100.
  - While reset is asserted: o_mem_rd=0 immediately, o_mem_addr=0x0100.
  - After release: BOOT, then the first fetch from 0x0100.
- Arithmetic and flags:
  - mv R1,#5; sub R1,#5 → R1=0, Z=1, N=0.
  - sub R1,#1 → R1=0xFFFF, N=1, Z=0.
  - Each instruction gives an o_retire pulse 3 cycles apart.
- Branches:
  - cmp R2,R2; jz +4 → PC = fetch address + 2 + 8.
  - jn not taken → PC += 2.
  - call R7 (register form) → jumps to old R7; R7 = return address.
- Wait states:
  - waitrequest=1 for 3 cycles on a fetch, then for 2 cycles on st R3→[R4=0x0040].
  - Addr, wrdata and o_mem_wr are held stable throughout; the st retires 2 cycles late.
- Memory ops:
  - st 0xBEEF to [0x0040]; ld R4,[R4] → R4=0xBEEF.
  - No simultaneous rd/wr at any point.
- Edge cases:
  - mvhi R5,#0x12 with R5=0x0034 → 0x1234.
  - PC at 0xFFFE fetch → PC wraps to 0x0000.
  - Illegal op 15 → NOP, retires in 3 cycles, flags unchanged.
